// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// Contents:
//   SUB_WIDTH_DEF - default operand width of the serial subtractor
//   sub_state_t   - serial subtractor FSM states (IDLE/RUN/DONE)
//   cnt_width()   - width of a counter that must hold values 0..w
package arith_pkg;

  localparam int unsigned SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor, purely combinational.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow-in
//   d    out difference bit  (a ^ b ^ bin)
//   bout out borrow-out      (a < b + bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Operands are accepted on an in_valid/in_ready handshake (IDLE only); the
// result is offered on an out_valid/out_ready handshake (DONE only).
// Optional feature macro: SUB_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   a, b, bin           minuend, subtrahend, borrow-in
//   out_valid/out_ready result handshake
//   diff, bout          difference (mod 2^WIDTH) and unsigned borrow-out
//   ovf                 signed overflow (SUB_OVF_EN only)
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  sub_state_t       state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             brw;
  logic [CNT_W-1:0] count;
  logic             bit_d, bit_bout;
  logic             last;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // count holds the number of bits already processed; the final bit is the
  // one processed while count == WIDTH-1, so count reaches WIDTH on the
  // same edge the FSM enters DONE.
  assign last      = (count == CNT_W'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (last)     next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      brw   <= 1'b0;
      count <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            count <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          brw   <= bit_bout;
          diff  <= {bit_d, diff[WIDTH-1:1]};
          count <= count + 1'b1;
          if (last) begin
            bout <= bit_bout;
`ifdef SUB_OVF_EN
            // On the final cycle the operand MSBs sit at bit 0 of the
            // shift registers and bit_d is the result MSB.
            ovf  <= (a_sr[0] != b_sr[0]) && (bit_d != a_sr[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int tests;
  int fails;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, failed so far %0d", fails);
    $fatal(1, "watchdog");
  end

  // Drives one operation starting at a negedge in IDLE. lat counts clock
  // edges from the accept edge (inclusive) to the edge that raises
  // out_valid. Result is captured after rdelay cycles of out_ready=0, then
  // popped; returns at a negedge with the block back in IDLE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input int rdelay,
                        output logic [W-1:0] od, output logic ob,
                        output logic oov, output int lat,
                        output logic timeout);
    int k;
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); @(negedge clk); k++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    while (!out_valid && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    timeout = !out_valid;
    repeat (rdelay) begin
      @(posedge clk); @(negedge clk);
    end
    od = diff; ob = bout;
`ifdef SUB_OVF_EN
    oov = ovf;
`else
    oov = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (diff !== 8'h00) begin fails++; $display("FAIL reset_diff got %h want 00", diff); end
    tests++; if (bout !== 1'b0) begin fails++; $display("FAIL reset_bout got %b want 0", bout); end
`ifdef SUB_OVF_EN
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] d; logic bo, ov, to; int lat;
    run_op(8'd5, 8'd3, 1'b0, 0, d, bo, ov, lat, to);
    tests++; if (to || d !== 8'h02 || bo !== 1'b0) begin fails++; $display("FAIL sub_5_3 got diff=%h bout=%b timeout=%b want 02/0", d, bo, to); end
    tests++; if (lat != 9) begin fails++; $display("FAIL latency_5_3 got %0d edges want 9", lat); end
    run_op(8'd3, 8'd5, 1'b0, 0, d, bo, ov, lat, to);
    tests++; if (to || d !== 8'hFE || bo !== 1'b1) begin fails++; $display("FAIL sub_3_5 got diff=%h bout=%b want FE/1", d, bo); end
    run_op(8'd0, 8'd0, 1'b1, 0, d, bo, ov, lat, to);
    tests++; if (to || d !== 8'hFF || bo !== 1'b1) begin fails++; $display("FAIL sub_0_0_bin got diff=%h bout=%b want FF/1", d, bo); end
    run_op(8'h6C, 8'h6C, 1'b0, 1, d, bo, ov, lat, to);
    tests++; if (to || d !== 8'h00 || bo !== 1'b0) begin fails++; $display("FAIL sub_equal got diff=%h bout=%b want 00/0", d, bo); end
    run_op(8'hC8, 8'h37, 1'b1, 2, d, bo, ov, lat, to);
    tests++; if (to || d !== 8'h90 || bo !== 1'b0) begin fails++; $display("FAIL sub_c8_37_bin got diff=%h bout=%b want 90/0", d, bo); end
  endtask

  task automatic test_backpressure();
    int k;
    a = 8'hA5; b = 8'h5A; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin @(posedge clk); @(negedge clk); k++; end
    tests++; if (!out_valid) begin fails++; $display("FAIL bp_wait got out_valid=0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;  // must be ignored while DONE
      @(posedge clk); @(negedge clk);
      tests++;
      if (diff !== 8'h4B || bout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cycle %0d got diff=%h bout=%b ov=%b ir=%b want 4B/0/1/0", i, diff, bout, out_valid, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_pop got ov=%b ir=%b want 0/1", out_valid, in_ready); end
  endtask

`ifdef SUB_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] d; logic bo, ov, to; int lat;
    run_op(8'h80, 8'h01, 1'b0, 0, d, bo, ov, lat, to);
    tests++; if (to || d !== 8'h7F || ov !== 1'b1 || bo !== 1'b0) begin fails++; $display("FAIL ovf_80_01 got diff=%h ovf=%b bout=%b want 7F/1/0", d, ov, bo); end
    run_op(8'h7F, 8'hFF, 1'b0, 0, d, bo, ov, lat, to);
    tests++; if (to || d !== 8'h80 || ov !== 1'b1 || bo !== 1'b1) begin fails++; $display("FAIL ovf_7f_ff got diff=%h ovf=%b bout=%b want 80/1/1", d, ov, bo); end
    run_op(8'h10, 8'h01, 1'b0, 0, d, bo, ov, lat, to);
    tests++; if (to || d !== 8'h0F || ov !== 1'b0) begin fails++; $display("FAIL ovf_10_01 got diff=%h ovf=%b want 0F/0", d, ov); end
  endtask
`endif

  task automatic test_in_valid_during_run();
    int k;
    a = 8'd5; b = 8'd3; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b1;  // held valid, must not be taken
    k = 0;
    while (!out_valid && k < 100) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL run_in_ready got %b want 0", in_ready); end
      @(posedge clk); @(negedge clk); k++;
    end
    in_valid = 1'b0;
    tests++; if (!out_valid || diff !== 8'h02 || bout !== 1'b0) begin fails++; $display("FAIL run_ignore got ov=%b diff=%h bout=%b want 1/02/0", out_valid, diff, bout); end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] d; logic bo, ov, to; int lat;
    a = 8'h12; b = 8'h34; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);  // now in RUN cycle 1
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);                  // RUN cycle 4
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 8'h00 || bout !== 1'b0) begin
      fails++;
      $display("FAIL mid_run_reset got ov=%b ir=%b diff=%h bout=%b want 0/1/00/0", out_valid, in_ready, diff, bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd9, 8'd4, 1'b0, 0, d, bo, ov, lat, to);
    tests++; if (to || d !== 8'h05 || bo !== 1'b0) begin fails++; $display("FAIL after_reset_9_4 got diff=%h bout=%b want 05/0", d, bo); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d, ta, tbv, exp_d; logic bo, ov, to, tbin, exp_b; int lat;
    logic [W:0] full;
    for (int n = 0; n < 1000; n++) begin
      ta = W'($urandom); tbv = W'($urandom); tbin = 1'($urandom);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ta, tbv, tbin, int'($urandom_range(0, 3)), d, bo, ov, lat, to);
      full  = {1'b0, ta} - {1'b0, tbv} - {{W{1'b0}}, tbin};
      exp_d = full[W-1:0];
      exp_b = full[W];
      tests++;
      if (to || d !== exp_d || bo !== exp_b) begin
        fails++;
        $display("FAIL rand op %0d %h-%h-%b got diff=%h bout=%b want %h/%b", n, ta, tbv, tbin, d, bo, exp_d, exp_b);
      end
`ifdef SUB_OVF_EN
      tests++;
      if (ov !== ((ta[W-1] != tbv[W-1]) && (exp_d[W-1] != ta[W-1]))) begin
        fails++;
        $display("FAIL rand ovf op %0d %h-%h-%b got %b", n, ta, tbv, tbin, ov);
      end
`endif
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
`ifdef SUB_OVF_EN
    test_ovf();
`endif
    test_in_valid_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
